// File: rtl/bullet_pkg.sv
// Shared coordinate type, screen constants and default tuning values for the bullet pool.
package bullet_pkg;
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t SCREEN_H = 10'd480;
  localparam coord_t PARK_X   = 10'd0;

  localparam coord_t DEF_SPEED    = 10'd5;
  localparam coord_t DEF_SPAWN_Y  = 10'd440;
  localparam coord_t DEF_TOP_Y    = 10'd10;
  localparam int     DEF_COOLDOWN = 8;
  localparam int     DEF_NSLOT    = 4;
endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: position and live flag with freeze > hit > move > spawn priority.
module bullet_slot
  import bullet_pkg::*;
#(
  parameter coord_t SPEED   = DEF_SPEED,
  parameter coord_t SPAWN_Y = DEF_SPAWN_Y,
  parameter coord_t TOP_Y   = DEF_TOP_Y
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               freeze,
  input  logic               hit,
  input  logic               move,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawn_x,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active
);

  // A slot only goes inactive through the park path, so idle slots always read x=0, y=480.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      x      <= PARK_X;
      y      <= SCREEN_H;
    end else if (!freeze) begin
      if (active && hit) begin
        active <= 1'b0;
        x      <= PARK_X;
        y      <= SCREEN_H;
      end else if (active && move) begin
        if (y < TOP_Y) begin
          active <= 1'b0;
          x      <= PARK_X;
          y      <= SCREEN_H;
        end else begin
          y <= y - SPEED;
        end
      end else if (spawn) begin
        active <= 1'b1;
        x      <= spawn_x;
        y      <= SPAWN_Y;
      end
    end
  end

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Pooled bullet scheduler: fire edge detect, spawn cooldown, lowest-free-slot allocation.
// Optional AUTOFIRE_EN: holding fire re-requests a spawn whenever the cooldown is clear.
module bullet_pool_ctrl
  import bullet_pkg::*;
#(
  parameter int     NSLOT    = DEF_NSLOT,
  parameter coord_t SPEED    = DEF_SPEED,
  parameter coord_t SPAWN_Y  = DEF_SPAWN_Y,
  parameter coord_t TOP_Y    = DEF_TOP_Y,
  parameter int     COOLDOWN = DEF_COOLDOWN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     fire,
  input  logic [COORD_W-1:0]       gun_x,
  input  logic [NSLOT-1:0]         hit,
  input  logic                     finish,
  output logic [COORD_W*NSLOT-1:0] bullet_x,
  output logic [COORD_W*NSLOT-1:0] bullet_y,
  output logic [NSLOT-1:0]         active,
  output logic                     fire_ack,
  output logic                     fire_drop,
  output logic                     pool_full
);

  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  logic             fire_q;
  logic [CW-1:0]    cooldown;
  logic             cool_zero;
  logic             req;
  logic             spawn_ok;
  logic             drop_now;
  logic             found;
  logic [NSLOT-1:0] spawn_sel;

  assign pool_full = &active;
  assign cool_zero = (cooldown == '0);

`ifdef AUTOFIRE_EN
  // Cooldown throttles a held button silently; only a full pool counts as a drop.
  assign req      = fire & ~finish & cool_zero;
  assign spawn_ok = req & ~pool_full;
  assign drop_now = req & pool_full;
`else
  logic fire_edge;
  assign fire_edge = fire & ~fire_q;
  assign req       = fire_edge & ~finish;
  assign spawn_ok  = req & cool_zero & ~pool_full;
  assign drop_now  = req & ~spawn_ok;
`endif

  // Lowest-index free slot, taken from the pre-update active mask.
  always_comb begin
    spawn_sel = '0;
    found     = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!active[i] && !found) begin
        spawn_sel[i] = spawn_ok;
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fire_q    <= 1'b0;
      cooldown  <= '0;
      fire_ack  <= 1'b0;
      fire_drop <= 1'b0;
    end else begin
      fire_q    <= fire;
      fire_ack  <= spawn_ok;
      fire_drop <= drop_now;
      if (!finish) begin
        if (spawn_ok)
          cooldown <= CW'(COOLDOWN);
        else if (frame_tick && !cool_zero)
          cooldown <= cooldown - CW'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      bullet_slot #(
        .SPEED   (SPEED),
        .SPAWN_Y (SPAWN_Y),
        .TOP_Y   (TOP_Y)
      ) u_slot (
        .clk     (clk),
        .reset   (reset),
        .freeze  (finish),
        .hit     (hit[gi]),
        .move    (frame_tick),
        .spawn   (spawn_sel[gi]),
        .spawn_x (gun_x),
        .x       (bullet_x[COORD_W*gi +: COORD_W]),
        .y       (bullet_y[COORD_W*gi +: COORD_W]),
        .active  (active[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Directed bench for bullet_pool_ctrl with a per-cycle behavioural pool model and literal pins.
module tb_bullet_pool_ctrl;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic          fire = 1'b0;
  logic [9:0]    gun_x = 10'd0;
  logic [N-1:0]  hit = '0;
  logic          finish = 1'b0;
  logic [10*N-1:0] bullet_x, bullet_y;
  logic [N-1:0]  active;
  logic          fire_ack, fire_drop, pool_full;

  int errors = 0;
  int checks = 0;

  bullet_pool_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .fire(fire),
    .gun_x(gun_x), .hit(hit), .finish(finish),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .active(active),
    .fire_ack(fire_ack), .fire_drop(fire_drop), .pool_full(pool_full)
  );

  always #5 clk = ~clk;

  // Behavioural model: whole-pool state as plain arrays and integers.
  bit ma[N];
  int mx[N], my[N];
  int mcd;
  bit mfq, mack, mdrop, mvalid = 1'b0;
  bit rising;
  int tgt;
  logic [10*N-1:0] ex_x, ex_y;
  logic [N-1:0]    ex_a;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [10*N-1:0] act, input logic [10*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Inputs only change 1 time unit after posedge, so at negedge they equal what the next edge samples.
  always @(negedge clk) begin
    if (mvalid) begin
      for (int i = 0; i < N; i++) begin
        ex_a[i]          = ma[i];
        ex_x[10*i +: 10] = 10'(mx[i]);
        ex_y[10*i +: 10] = 10'(my[i]);
      end
      chkv("m_active", {{(10*N-N){1'b0}}, active}, {{(10*N-N){1'b0}}, ex_a});
      chkv("m_x", bullet_x, ex_x);
      chkv("m_y", bullet_y, ex_y);
      chk("m_ack", int'(fire_ack), int'(mack));
      chk("m_drop", int'(fire_drop), int'(mdrop));
      chk("m_full", int'(pool_full), int'(ex_a == '1));
    end
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        ma[i] = 1'b0; mx[i] = 0; my[i] = 480;
      end
      mcd = 0; mfq = 1'b0; mack = 1'b0; mdrop = 1'b0; mvalid = 1'b1;
    end else if (mvalid) begin
      rising = fire && !mfq;
      mfq    = fire;
      mack   = 1'b0;
      mdrop  = 1'b0;
      if (!finish) begin
        tgt = -1;
        for (int i = 0; i < N; i++)
          if (!ma[i] && tgt < 0) tgt = i;
        if (rising) begin
          if (mcd == 0 && tgt >= 0) mack = 1'b1;
          else mdrop = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
          if (ma[i] && hit[i]) begin
            ma[i] = 1'b0; mx[i] = 0; my[i] = 480;
          end else if (ma[i] && frame_tick) begin
            if (my[i] < 10) begin
              ma[i] = 1'b0; mx[i] = 0; my[i] = 480;
            end else begin
              my[i] = my[i] - 5;
            end
          end else if (mack && i == tgt) begin
            ma[i] = 1'b1; mx[i] = int'(gun_x); my[i] = 440;
          end
        end
        if (mack) mcd = 8;
        else if (frame_tick && mcd > 0) mcd = mcd - 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
    end
  endtask

  task automatic fire_pulse(input int gx, input int eack, input int edrop);
    gun_x = 10'(gx);
    fire  = 1'b1;
    step();
    chk("ack", int'(fire_ack), eack);
    chk("drop", int'(fire_drop), edrop);
    $display("fire gun_x=%0d ack=%0d drop=%0d active=%b", gx, fire_ack, fire_drop, active);
    fire = 1'b0;
    step();
  endtask

  function automatic int ys(input int i);
    return int'(bullet_y[10*i +: 10]);
  endfunction

  function automatic int xs(input int i);
    return int'(bullet_x[10*i +: 10]);
  endfunction

  initial begin
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_active", int'(active), 0);
    chk("rst_y3", ys(3), 480);
    chk("rst_x0", xs(0), 0);

    // First spawn and motion down to retirement at the top
    fire_pulse(320, 1, 0);
    chk("sp_active", int'(active), 1);
    chk("sp_x0", xs(0), 320);
    tick(10);
    chk("mv_y0", ys(0), 390);
    tick(77);
    chk("mv_y5", ys(0), 5);
    tick(1);
    chk("top_active", int'(active), 0);
    chk("top_y0", ys(0), 480);

    // Fill the pool, drop on full, reuse a hit slot
    fire_pulse(100, 1, 0); tick(8);
    fire_pulse(200, 1, 0); tick(8);
    fire_pulse(300, 1, 0); tick(8);
    fire_pulse(400, 1, 0); tick(8);
    chk("full_active", int'(active), 15);
    chk("full_flag", int'(pool_full), 1);
    fire_pulse(500, 0, 1);
    hit = 4'b0100;
    step();
    hit = '0;
    chk("hit_active", int'(active), 11);
    fire_pulse(600, 1, 0);
    chk("reuse_x2", xs(2), 600);
    chk("reuse_y2", ys(2), 440);

    // Cooldown boundary: drops at 3 and 7 ticks, ack at 8
    hit = 4'hF;
    step();
    hit = '0;
    tick(3);
    fire_pulse(610, 0, 1);
    tick(4);
    fire_pulse(620, 0, 1);
    tick(1);
    fire_pulse(700, 1, 0);
    chk("cd_active", int'(active), 1);

    // Freeze with two live bullets, then reset while frozen
    tick(8);
    fire_pulse(710, 1, 0);
    finish = 1'b1;
    tick(20);
    fire_pulse(720, 0, 0);
    fire_pulse(730, 0, 0);
    chk("frz_active", int'(active), 3);
    chk("frz_y0", ys(0), 400);
    chk("frz_y1", ys(1), 440);
    chk("frz_x0", xs(0), 700);
    chk("frz_x1", xs(1), 710);
    reset = 1'b1;
    step();
    chk("frz_rst_active", int'(active), 0);
    chk("frz_rst_y1", ys(1), 480);
    reset = 1'b0;
    finish = 1'b0;
    step();

    // Hit, tick and fire edge in one cycle
    fire_pulse(50, 1, 0);
    tick(8);
    hit = 4'b0001;
    frame_tick = 1'b1;
    fire = 1'b1;
    gun_x = 10'd60;
    step();
    chk("same_active", int'(active), 2);
    chk("same_y1", ys(1), 440);
    chk("same_x1", xs(1), 60);
    chk("same_y0", ys(0), 480);
    chk("same_ack", int'(fire_ack), 1);
    hit = '0;
    frame_tick = 1'b0;
    fire = 1'b0;
    step();
    tick(7);
    fire_pulse(70, 0, 1);
    tick(1);
    fire_pulse(80, 1, 0);
    chk("same_end_active", int'(active), 3);

    step(); step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bullet_pool_ctrl.md
Name: bullet_pool_ctrl

Overview:
- Scheduler that shares a fixed pool of NSLOT bullet slots between player fire requests.
- Allocates a free slot on each fire press and advances active bullets once per frame tick.
- Retires a bullet on a collision or when it reaches the top of the screen.
- Sits between the button/gun-position logic and the VGA renderer/collision unit; replaces single-bullet handling with a pooled, rate-limited scheme.

Parameters:
- NSLOT, 4, number of bullet slots (1..8)
- SPEED, 5, pixels per frame tick a bullet moves upward
- SPAWN_Y, 440, y coordinate of a newly fired bullet
- TOP_Y, 10, bullet retires when y < TOP_Y at a move tick
- COOLDOWN, 8, frame ticks that must elapse after a spawn before the next spawn

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame; motion and cooldown step
- fire  in  1  fire button level, already debounced
- gun_x  in  10  current gun x coordinate
- hit  in  NSLOT  per-slot collision pulse from the collision unit
- finish  in  1  game over; freeze all state
- bullet_x  out  10*NSLOT  packed x per slot; slot i at [10i+9:10i]
- bullet_y  out  10*NSLOT  packed y per slot
- active  out  NSLOT  slot i holds a live bullet
- fire_ack  out  1  one-cycle pulse when a spawn occurs
- fire_drop  out  1  one-cycle pulse when a fire edge is rejected
- pool_full  out  1  all slots active (combinational from active)

Behaviour:
- Reset (reset takes precedence over everything):
  - all slots inactive, x=0, y=480 (parked)
  - cooldown=0, fire_q=0, fire_ack=0, fire_drop=0
- Inactive slots always present x=0, y=480.
- Edge detect:
  - fire_q is fire registered each cycle.
  - fire_edge = fire & ~fire_q.
- Spawn decision, evaluated in the cycle where fire_edge=1:
  - If cooldown==0 and a free slot exists: pick the lowest-index slot with active=0, taken from registered state.
  - At the next clock edge that slot becomes active with x=gun_x and y=SPAWN_Y; fire_ack=1 for one cycle; cooldown=COOLDOWN.
  - Otherwise fire_drop=1 for one cycle and no state changes.
- Cooldown: decrements by 1 on each frame_tick while nonzero; saturates at 0.
- Per-slot update priority: reset > finish > hit[i] > frame_tick move > spawn.
  - hit[i] on an active slot: slot parks and goes inactive next edge.
  - hit[i] on an inactive slot: ignored.
  - frame_tick on an active slot with y < TOP_Y: slot parks and goes inactive. Otherwise y <= y - SPEED. No wrap possible since TOP_Y >= SPEED.
  - A slot spawned in a given cycle is not moved by a frame_tick in that same cycle.
- Simultaneous events:
  - hit on slot j and spawn in the same cycle: the spawn cannot target j, because the free mask is pre-update.
  - fire_edge and frame_tick together: spawn proceeds, and cooldown is loaded with COOLDOWN rather than decremented.
- finish=1:
  - all slot registers and cooldown hold
  - fire edges ignored (no ack, no drop); fire_q still tracks fire
- Latency: fire rising edge sampled at edge n → fire_edge in cycle n → active/x/y visible after edge n+1.

Optional Feature:
- Macro AUTOFIRE_EN.
- Defined: while fire is held high, a new spawn request is generated each cycle in which cooldown==0. fire_drop pulses only for requests rejected due to pool full, not for cooldown.
- Undefined: spawns occur only on rising edges, as above.

Decomposition:
- Package bullet_pkg:
  - COORD_W=10
  - SCREEN_H=480 (park y), PARK_X=0
  - typedef coord_t logic [COORD_W-1:0]
  - default SPEED/SPAWN_Y/TOP_Y constants
- Sub-module bullet_slot:
  - one slot's x/y/active registers with hit/move/spawn/freeze priority
  - instantiated NSLOT times via generate
- The top holds edge detect, cooldown counter, free-slot priority encoder and output packing.

Test Plan:
- Reset then fire pulse with gun_x=320 → one cycle later active=0001, slot0 x=320 y=440, fire_ack=1 for 1 cycle, cooldown=8.
- Slot0 live at y=440, 10 frame_ticks → y=390. Drive to y=5 then a frame_tick → active[0]=0, x=0, y=480.
- Fire edges spaced 8 frame ticks apart, 5 times, no hits → slots 0..3 filled, 5th edge gives fire_drop=1 with pool_full=1; hit[2] then next fire → slot 2 reused.
- Fire edge 3 ticks after a spawn → fire_drop=1, no new slot; fire again after tick 8 → fire_ack.
- finish=1 with 2 live bullets, 20 frame_ticks plus fire edges → x/y/active unchanged, no ack/drop. Reset during finish → all parked.
- Same cycle: hit[0] + frame_tick + fire_edge with slot0 live and slot1 free → slot0 parked, spawn in slot1 at y=440 (not moved), cooldown=8.
